procyon_lsu_am: RTL and testbench

//  LSU address-generation/arbitration stage. It directly feeds procyon_lsu_d1.
//  - Each cycle, picks at most one op from three sources: SQ retiring store, LQ replay, new op from the LSU RS.
//  - Computes the effective address for new ops.
//  - Requests LQ/SQ allocation for new ops.
//  - Registers the winning op into the stage-1 input bundle.

---
 rtl/procyon_lsu_am_pkg.sv | 34 +++
 rtl/procyon_lsu_am_if.sv | 79 +++++++
 rtl/procyon_lsu_am_arb.sv | 46 ++++
 rtl/procyon_lsu_am.sv | 116 +++++++++++
 tb/tb_procyon_lsu_am.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/procyon_lsu_am_pkg.sv
// Shared LSU definitions: function encodings, grant bit positions and decode helpers.
// Used by the address-generation/arbitration stage and its arbiter.
package procyon_pkg;

    localparam int PCYN_LSU_FUNC_WIDTH = 4;

    typedef enum logic [PCYN_LSU_FUNC_WIDTH-1:0] {
        PCYN_LSU_FUNC_LB  = 4'd0,
        PCYN_LSU_FUNC_LH  = 4'd1,
        PCYN_LSU_FUNC_LW  = 4'd2,
        PCYN_LSU_FUNC_LBU = 4'd3,
        PCYN_LSU_FUNC_LHU = 4'd4,
        PCYN_LSU_FUNC_SB  = 4'd5,
        PCYN_LSU_FUNC_SH  = 4'd6,
        PCYN_LSU_FUNC_SW  = 4'd7
    } pcyn_lsu_func_t;

    localparam int GNT_NEW    = 0;
    localparam int GNT_REPLAY = 1;
    localparam int GNT_RETIRE = 2;

    function automatic logic is_store(input logic [PCYN_LSU_FUNC_WIDTH-1:0] func);
        return (func == PCYN_LSU_FUNC_SB) || (func == PCYN_LSU_FUNC_SH) || (func == PCYN_LSU_FUNC_SW);
    endfunction

    function automatic logic is_half(input logic [PCYN_LSU_FUNC_WIDTH-1:0] func);
        return (func == PCYN_LSU_FUNC_LH) || (func == PCYN_LSU_FUNC_LHU) || (func == PCYN_LSU_FUNC_SH);
    endfunction

    function automatic logic is_word(input logic [PCYN_LSU_FUNC_WIDTH-1:0] func);
        return (func == PCYN_LSU_FUNC_LW) || (func == PCYN_LSU_FUNC_SW);
    endfunction

endpackage

// File: rtl/procyon_lsu_am_if.sv
// Bus bundle between the LSU reservation station / LQ / SQ / D1 and the AM stage.
// o_misaligned exists only when PCYN_LSU_AM_MISALIGN_EN is defined.
interface procyon_lsu_am_if
    import procyon_pkg::*;
#(
    parameter int OPTN_DATA_WIDTH    = 32,
    parameter int OPTN_ADDR_WIDTH    = 32,
    parameter int OPTN_LQ_DEPTH      = 8,
    parameter int OPTN_SQ_DEPTH      = 8,
    parameter int OPTN_ROB_IDX_WIDTH = 5
);
    logic                           i_flush;
    logic                           i_valid;
    logic [PCYN_LSU_FUNC_WIDTH-1:0] i_lsu_func;
    logic [OPTN_DATA_WIDTH-1:0]     i_src_a;
    logic [OPTN_DATA_WIDTH-1:0]     i_src_b;
    logic [OPTN_DATA_WIDTH-1:0]     i_imm;
    logic [OPTN_ROB_IDX_WIDTH-1:0]  i_tag;
    logic                           o_stall;
    logic                           i_lq_full;
    logic                           i_sq_full;
    logic                           o_alloc_lq;
    logic                           o_alloc_sq;
    logic [OPTN_SQ_DEPTH-1:0]       i_alloc_sq_select;
    logic                           i_replay_en;
    logic [PCYN_LSU_FUNC_WIDTH-1:0] i_replay_lsu_func;
    logic [OPTN_LQ_DEPTH-1:0]       i_replay_lq_select;
    logic [OPTN_ROB_IDX_WIDTH-1:0]  i_replay_tag;
    logic [OPTN_ADDR_WIDTH-1:0]     i_replay_addr;
    logic                           o_replay_ack;
    logic                           i_sq_retire_en;
    logic [OPTN_SQ_DEPTH-1:0]       i_sq_retire_select;
    logic [PCYN_LSU_FUNC_WIDTH-1:0] i_sq_retire_lsu_func;
    logic [OPTN_ROB_IDX_WIDTH-1:0]  i_sq_retire_tag;
    logic [OPTN_ADDR_WIDTH-1:0]     i_sq_retire_addr;
    logic [OPTN_DATA_WIDTH-1:0]     i_sq_retire_data;
    logic                           o_sq_retire_ack;
    logic                           o_valid;
    logic [PCYN_LSU_FUNC_WIDTH-1:0] o_lsu_func;
    logic [OPTN_LQ_DEPTH-1:0]       o_lq_select;
    logic [OPTN_SQ_DEPTH-1:0]       o_sq_select;
    logic [OPTN_ROB_IDX_WIDTH-1:0]  o_tag;
    logic [OPTN_ADDR_WIDTH-1:0]     o_addr;
    logic [OPTN_DATA_WIDTH-1:0]     o_retire_data;
    logic                           o_retire;
    logic                           o_replay;
`ifdef PCYN_LSU_AM_MISALIGN_EN
    logic                           o_misaligned;
`endif

    modport master (
        output i_flush, i_valid, i_lsu_func, i_src_a, i_src_b, i_imm, i_tag,
               i_lq_full, i_sq_full, i_alloc_sq_select,
               i_replay_en, i_replay_lsu_func, i_replay_lq_select, i_replay_tag, i_replay_addr,
               i_sq_retire_en, i_sq_retire_select, i_sq_retire_lsu_func, i_sq_retire_tag,
               i_sq_retire_addr, i_sq_retire_data,
        input  o_stall, o_alloc_lq, o_alloc_sq, o_replay_ack, o_sq_retire_ack,
               o_valid, o_lsu_func, o_lq_select, o_sq_select, o_tag, o_addr, o_retire_data,
               o_retire, o_replay
`ifdef PCYN_LSU_AM_MISALIGN_EN
        , input o_misaligned
`endif
    );

    modport slave (
        input  i_flush, i_valid, i_lsu_func, i_src_a, i_src_b, i_imm, i_tag,
               i_lq_full, i_sq_full, i_alloc_sq_select,
               i_replay_en, i_replay_lsu_func, i_replay_lq_select, i_replay_tag, i_replay_addr,
               i_sq_retire_en, i_sq_retire_select, i_sq_retire_lsu_func, i_sq_retire_tag,
               i_sq_retire_addr, i_sq_retire_data,
        output o_stall, o_alloc_lq, o_alloc_sq, o_replay_ack, o_sq_retire_ack,
               o_valid, o_lsu_func, o_lq_select, o_sq_select, o_tag, o_addr, o_retire_data,
               o_retire, o_replay
`ifdef PCYN_LSU_AM_MISALIGN_EN
        , output o_misaligned
`endif
    );

endinterface

// File: rtl/procyon_lsu_am_arb.sv
// Three-way priority arbiter (retire > replay > new) with a saturating starvation
// counter that lets a blocked new op win once it has lost OPTN_STARVE_LIMIT times.
module procyon_lsu_am_arb
    import procyon_pkg::*;
#(
    parameter int OPTN_STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       flush,
    input  logic       valid,
    input  logic       retire_req,
    input  logic       replay_req,
    input  logic       new_req,
    output logic [2:0] grant
);
    localparam int CW = $clog2(OPTN_STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(OPTN_STARVE_LIMIT);

    logic [CW-1:0] starve_cnt;
    logic          starved;

    assign starved = new_req && (starve_cnt == LIMIT);

    always_comb begin
        grant = '0;
        if (!flush) begin
            if (starved)         grant[GNT_NEW]    = 1'b1;
            else if (retire_req) grant[GNT_RETIRE] = 1'b1;
            else if (replay_req) grant[GNT_REPLAY] = 1'b1;
            else if (new_req)    grant[GNT_NEW]    = 1'b1;
        end
    end

    // A full queue (valid but not eligible) leaves the count untouched.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            starve_cnt <= '0;
        end else if (flush || !valid || grant[GNT_NEW]) begin
            starve_cnt <= '0;
        end else if (new_req && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/procyon_lsu_am.sv
// LSU address-generation/arbitration stage feeding procyon_lsu_d1.
// Optional misalignment flag enabled by defining PCYN_LSU_AM_MISALIGN_EN.
module procyon_lsu_am
    import procyon_pkg::*;
#(
    parameter int OPTN_DATA_WIDTH    = 32,
    parameter int OPTN_ADDR_WIDTH    = 32,
    parameter int OPTN_LQ_DEPTH      = 8,
    parameter int OPTN_SQ_DEPTH      = 8,
    parameter int OPTN_ROB_IDX_WIDTH = 5,
    parameter int OPTN_STARVE_LIMIT  = 4
) (
    input logic            clk,
    input logic            n_rst,
    procyon_lsu_am_if.slave bus
);
    logic [2:0]                     grant;
    logic                           new_is_store;
    logic                           new_req;
    logic [OPTN_ADDR_WIDTH-1:0]     new_addr;
    logic [PCYN_LSU_FUNC_WIDTH-1:0] func_nxt;
    logic [OPTN_ROB_IDX_WIDTH-1:0]  tag_nxt;
    logic [OPTN_ADDR_WIDTH-1:0]     addr_nxt;
    logic [OPTN_LQ_DEPTH-1:0]       lq_select_nxt;
    logic [OPTN_SQ_DEPTH-1:0]       sq_select_nxt;
    logic [OPTN_DATA_WIDTH-1:0]     data_nxt;

    assign new_is_store = is_store(bus.i_lsu_func);
    assign new_req      = bus.i_valid && !(new_is_store ? bus.i_sq_full : bus.i_lq_full);
    assign new_addr     = OPTN_ADDR_WIDTH'(bus.i_src_a + bus.i_imm);

    procyon_lsu_am_arb #(
        .OPTN_STARVE_LIMIT(OPTN_STARVE_LIMIT)
    ) u_arb (
        .clk        (clk),
        .n_rst      (n_rst),
        .flush      (bus.i_flush),
        .valid      (bus.i_valid),
        .retire_req (bus.i_sq_retire_en),
        .replay_req (bus.i_replay_en),
        .new_req    (new_req),
        .grant      (grant)
    );

    assign bus.o_stall         = bus.i_valid && !grant[GNT_NEW];
    assign bus.o_alloc_lq      = grant[GNT_NEW] && !new_is_store;
    assign bus.o_alloc_sq      = grant[GNT_NEW] && new_is_store;
    assign bus.o_replay_ack    = grant[GNT_REPLAY];
    assign bus.o_sq_retire_ack = grant[GNT_RETIRE];

    // New loads leave lq_select at zero; D1 substitutes the LQ allocation select.
    always_comb begin
        func_nxt      = '0;
        tag_nxt       = '0;
        addr_nxt      = '0;
        lq_select_nxt = '0;
        sq_select_nxt = '0;
        data_nxt      = '0;
        if (grant[GNT_RETIRE]) begin
            func_nxt      = bus.i_sq_retire_lsu_func;
            tag_nxt       = bus.i_sq_retire_tag;
            addr_nxt      = bus.i_sq_retire_addr;
            sq_select_nxt = bus.i_sq_retire_select;
            data_nxt      = bus.i_sq_retire_data;
        end else if (grant[GNT_REPLAY]) begin
            func_nxt      = bus.i_replay_lsu_func;
            tag_nxt       = bus.i_replay_tag;
            addr_nxt      = bus.i_replay_addr;
            lq_select_nxt = bus.i_replay_lq_select;
        end else if (grant[GNT_NEW]) begin
            func_nxt = bus.i_lsu_func;
            tag_nxt  = bus.i_tag;
            addr_nxt = new_addr;
            if (new_is_store) begin
                sq_select_nxt = bus.i_alloc_sq_select;
                data_nxt      = bus.i_src_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            bus.o_valid       <= 1'b0;
            bus.o_retire      <= 1'b0;
            bus.o_replay      <= 1'b0;
            bus.o_lsu_func    <= '0;
            bus.o_tag         <= '0;
            bus.o_addr        <= '0;
            bus.o_lq_select   <= '0;
            bus.o_sq_select   <= '0;
            bus.o_retire_data <= '0;
        end else begin
            bus.o_valid       <= (|grant) && !bus.i_flush;
            bus.o_retire      <= grant[GNT_RETIRE];
            bus.o_replay      <= grant[GNT_REPLAY];
            bus.o_lsu_func    <= func_nxt;
            bus.o_tag         <= tag_nxt;
            bus.o_addr        <= addr_nxt;
            bus.o_lq_select   <= lq_select_nxt;
            bus.o_sq_select   <= sq_select_nxt;
            bus.o_retire_data <= data_nxt;
        end
    end

`ifdef PCYN_LSU_AM_MISALIGN_EN
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            bus.o_misaligned <= 1'b0;
        end else begin
            bus.o_misaligned <= (is_half(func_nxt) && addr_nxt[0]) ||
                                (is_word(func_nxt) && (|addr_nxt[1:0]));
        end
    end
`endif

endmodule

// File: tb/tb_procyon_lsu_am.sv
// Directed self-checking bench for procyon_lsu_am; the misalignment scenario runs
// only when PCYN_LSU_AM_MISALIGN_EN is defined.
module tb_procyon_lsu_am;
    import procyon_pkg::*;

    logic clk;
    logic n_rst;
    int   checks   = 0;
    int   failures = 0;

    procyon_lsu_am_if #(
        .OPTN_DATA_WIDTH(32), .OPTN_ADDR_WIDTH(32), .OPTN_LQ_DEPTH(8),
        .OPTN_SQ_DEPTH(8), .OPTN_ROB_IDX_WIDTH(5)
    ) bus ();

    procyon_lsu_am #(
        .OPTN_DATA_WIDTH(32), .OPTN_ADDR_WIDTH(32), .OPTN_LQ_DEPTH(8),
        .OPTN_SQ_DEPTH(8), .OPTN_ROB_IDX_WIDTH(5), .OPTN_STARVE_LIMIT(4)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clear_inputs();
        bus.i_flush = 0; bus.i_valid = 0; bus.i_lsu_func = '0; bus.i_src_a = '0;
        bus.i_src_b = '0; bus.i_imm = '0; bus.i_tag = '0; bus.i_lq_full = 0;
        bus.i_sq_full = 0; bus.i_alloc_sq_select = '0; bus.i_replay_en = 0;
        bus.i_replay_lsu_func = '0; bus.i_replay_lq_select = '0; bus.i_replay_tag = '0;
        bus.i_replay_addr = '0; bus.i_sq_retire_en = 0; bus.i_sq_retire_select = '0;
        bus.i_sq_retire_lsu_func = '0; bus.i_sq_retire_tag = '0; bus.i_sq_retire_addr = '0;
        bus.i_sq_retire_data = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clear_inputs();
        step();
    endtask

    task automatic set_retire_replay_fields();
        bus.i_sq_retire_select = 8'h04; bus.i_sq_retire_lsu_func = PCYN_LSU_FUNC_SW;
        bus.i_sq_retire_tag = 5'd7; bus.i_sq_retire_addr = 32'h0000_2000;
        bus.i_sq_retire_data = 32'h0000_DEAD;
        bus.i_replay_lq_select = 8'h10; bus.i_replay_lsu_func = PCYN_LSU_FUNC_LW;
        bus.i_replay_tag = 5'd9; bus.i_replay_addr = 32'h0000_3000;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        clear_inputs();
        bus.i_sq_retire_en = 1; bus.i_valid = 1;
        step();
        step();
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL reset_o_valid got=%0h exp=0", bus.o_valid); end
        checks++; if (bus.o_retire !== 1'b0) begin failures++; $display("FAIL reset_o_retire got=%0h exp=0", bus.o_retire); end
        checks++; if (bus.o_replay !== 1'b0) begin failures++; $display("FAIL reset_o_replay got=%0h exp=0", bus.o_replay); end
        checks++; if (bus.o_addr !== 32'h0) begin failures++; $display("FAIL reset_o_addr got=%h exp=0", bus.o_addr); end
        checks++; if (bus.o_sq_select !== 8'h0) begin failures++; $display("FAIL reset_o_sq_select got=%h exp=0", bus.o_sq_select); end
        checks++; if (dut.u_arb.starve_cnt !== 3'd0) begin failures++; $display("FAIL reset_starve_cnt got=%0d exp=0", dut.u_arb.starve_cnt); end
        n_rst = 1'b1;
        idle();
    endtask

    task automatic test_starvation();
        clear_inputs();
        set_retire_replay_fields();
        bus.i_valid = 1; bus.i_lsu_func = PCYN_LSU_FUNC_LW;
        bus.i_src_a = 32'h100; bus.i_imm = 32'h4; bus.i_tag = 5'd3;
        for (int i = 0; i < 4; i++) begin
            logic ret;
            ret = (i % 2 == 0);
            bus.i_sq_retire_en = ret; bus.i_replay_en = 1;
            #3;
            checks++; if (bus.o_sq_retire_ack !== ret) begin failures++; $display("FAIL starve_retire_ack[%0d] got=%0h exp=%0h", i, bus.o_sq_retire_ack, ret); end
            checks++; if (bus.o_replay_ack !== !ret) begin failures++; $display("FAIL starve_replay_ack[%0d] got=%0h exp=%0h", i, bus.o_replay_ack, !ret); end
            checks++; if (bus.o_stall !== 1'b1 || bus.o_alloc_lq !== 1'b0) begin failures++; $display("FAIL starve_stall[%0d] got=%0h/%0h exp=1/0", i, bus.o_stall, bus.o_alloc_lq); end
            step();
            checks++; if (bus.o_valid !== 1'b1 || bus.o_retire !== ret || bus.o_replay !== !ret) begin failures++; $display("FAIL starve_kind[%0d] got=%0h%0h%0h exp=1%0h%0h", i, bus.o_valid, bus.o_retire, bus.o_replay, ret, !ret); end
            checks++; if (bus.o_addr !== (ret ? 32'h2000 : 32'h3000)) begin failures++; $display("FAIL starve_addr[%0d] got=%h", i, bus.o_addr); end
            checks++; if (bus.o_sq_select !== (ret ? 8'h04 : 8'h00) || bus.o_lq_select !== (ret ? 8'h00 : 8'h10)) begin failures++; $display("FAIL starve_select[%0d] got=%h/%h", i, bus.o_sq_select, bus.o_lq_select); end
            checks++; if (dut.u_arb.starve_cnt !== 3'(i + 1)) begin failures++; $display("FAIL starve_cnt[%0d] got=%0d exp=%0d", i, dut.u_arb.starve_cnt, i + 1); end
        end
        bus.i_sq_retire_en = 1; bus.i_replay_en = 1;
        #3;
        checks++; if (bus.o_stall !== 1'b0 || bus.o_alloc_lq !== 1'b1) begin failures++; $display("FAIL starve_win_alloc got=%0h/%0h exp=0/1", bus.o_stall, bus.o_alloc_lq); end
        checks++; if (bus.o_sq_retire_ack !== 1'b0 || bus.o_replay_ack !== 1'b0) begin failures++; $display("FAIL starve_win_acks got=%0h/%0h exp=0/0", bus.o_sq_retire_ack, bus.o_replay_ack); end
        step();
        checks++; if (bus.o_valid !== 1'b1 || bus.o_retire !== 1'b0 || bus.o_replay !== 1'b0) begin failures++; $display("FAIL starve_win_kind got=%0h%0h%0h exp=100", bus.o_valid, bus.o_retire, bus.o_replay); end
        checks++; if (bus.o_addr !== 32'h104 || bus.o_tag !== 5'd3) begin failures++; $display("FAIL starve_win_addr got=%h/%0d exp=104/3", bus.o_addr, bus.o_tag); end
        checks++; if (dut.u_arb.starve_cnt !== 3'd0) begin failures++; $display("FAIL starve_cnt_clear got=%0d exp=0", dut.u_arb.starve_cnt); end
        idle();
    endtask

    task automatic test_addr_wrap();
        clear_inputs();
        bus.i_valid = 1; bus.i_lsu_func = PCYN_LSU_FUNC_LW; bus.i_tag = 5'd12;
        bus.i_src_a = 32'hFFFF_FFFC; bus.i_imm = 32'h8; bus.i_src_b = 32'h5555_5555;
        #3;
        checks++; if (bus.o_alloc_lq !== 1'b1 || bus.o_alloc_sq !== 1'b0 || bus.o_stall !== 1'b0) begin failures++; $display("FAIL wrap_alloc got=%0h%0h%0h exp=100", bus.o_alloc_lq, bus.o_alloc_sq, bus.o_stall); end
        step();
        checks++; if (bus.o_valid !== 1'b1 || bus.o_addr !== 32'h4) begin failures++; $display("FAIL wrap_addr got=%0h/%h exp=1/00000004", bus.o_valid, bus.o_addr); end
        checks++; if (bus.o_lsu_func !== PCYN_LSU_FUNC_LW || bus.o_tag !== 5'd12) begin failures++; $display("FAIL wrap_func_tag got=%0h/%0d exp=2/12", bus.o_lsu_func, bus.o_tag); end
        checks++; if (bus.o_retire_data !== 32'h0 || bus.o_sq_select !== 8'h0) begin failures++; $display("FAIL wrap_load_data got=%h/%h exp=0/0", bus.o_retire_data, bus.o_sq_select); end
        bus.i_lsu_func = PCYN_LSU_FUNC_SW; bus.i_src_a = 32'h40; bus.i_imm = 32'hFFFF_FFFC;
        bus.i_src_b = 32'hCAFE_BABE; bus.i_alloc_sq_select = 8'h20;
        #3;
        checks++; if (bus.o_alloc_sq !== 1'b1 || bus.o_alloc_lq !== 1'b0) begin failures++; $display("FAIL store_alloc got=%0h/%0h exp=1/0", bus.o_alloc_sq, bus.o_alloc_lq); end
        step();
        checks++; if (bus.o_addr !== 32'h3C || bus.o_sq_select !== 8'h20) begin failures++; $display("FAIL store_addr got=%h/%h exp=3c/20", bus.o_addr, bus.o_sq_select); end
        checks++; if (bus.o_retire_data !== 32'hCAFE_BABE || bus.o_retire !== 1'b0) begin failures++; $display("FAIL store_data got=%h/%0h exp=cafebabe/0", bus.o_retire_data, bus.o_retire); end
        idle();
    endtask

    task automatic test_sq_full();
        clear_inputs();
        bus.i_valid = 1; bus.i_lsu_func = PCYN_LSU_FUNC_SW; bus.i_src_a = 32'h80;
        bus.i_imm = 32'h10; bus.i_src_b = 32'h1234_5678; bus.i_alloc_sq_select = 8'h02;
        bus.i_sq_full = 1; bus.i_lq_full = 1;
        for (int i = 0; i < 10; i++) begin
            #3;
            checks++; if (bus.o_stall !== 1'b1 || bus.o_alloc_sq !== 1'b0) begin failures++; $display("FAIL full_stall[%0d] got=%0h/%0h exp=1/0", i, bus.o_stall, bus.o_alloc_sq); end
            step();
            checks++; if (bus.o_valid !== 1'b0 || dut.u_arb.starve_cnt !== 3'd0) begin failures++; $display("FAIL full_hold[%0d] got=%0h/%0d exp=0/0", i, bus.o_valid, dut.u_arb.starve_cnt); end
        end
        bus.i_sq_full = 0;
        #3;
        checks++; if (bus.o_stall !== 1'b0 || bus.o_alloc_sq !== 1'b1 || bus.o_alloc_lq !== 1'b0) begin failures++; $display("FAIL full_drop got=%0h%0h%0h exp=010", bus.o_stall, bus.o_alloc_sq, bus.o_alloc_lq); end
        step();
        checks++; if (bus.o_valid !== 1'b1 || bus.o_addr !== 32'h90 || bus.o_sq_select !== 8'h02) begin failures++; $display("FAIL full_out got=%0h/%h/%h exp=1/90/02", bus.o_valid, bus.o_addr, bus.o_sq_select); end
        checks++; if (bus.o_retire_data !== 32'h1234_5678 || bus.o_lsu_func !== PCYN_LSU_FUNC_SW) begin failures++; $display("FAIL full_data got=%h/%0h exp=12345678/7", bus.o_retire_data, bus.o_lsu_func); end
        idle();
    endtask

    task automatic test_flush();
        clear_inputs();
        set_retire_replay_fields();
        bus.i_valid = 1; bus.i_lsu_func = PCYN_LSU_FUNC_LW; bus.i_src_a = 32'h500;
        bus.i_sq_retire_en = 1; bus.i_replay_en = 1; bus.i_flush = 1;
        #3;
        checks++; if (bus.o_sq_retire_ack !== 1'b0 || bus.o_replay_ack !== 1'b0) begin failures++; $display("FAIL flush_acks got=%0h/%0h exp=0/0", bus.o_sq_retire_ack, bus.o_replay_ack); end
        checks++; if (bus.o_alloc_lq !== 1'b0 || bus.o_alloc_sq !== 1'b0 || bus.o_stall !== 1'b1) begin failures++; $display("FAIL flush_alloc got=%0h%0h%0h exp=001", bus.o_alloc_lq, bus.o_alloc_sq, bus.o_stall); end
        step();
        checks++; if (bus.o_valid !== 1'b0 || dut.u_arb.starve_cnt !== 3'd0) begin failures++; $display("FAIL flush_out got=%0h/%0d exp=0/0", bus.o_valid, dut.u_arb.starve_cnt); end
        bus.i_flush = 0;
        #3;
        checks++; if (bus.o_sq_retire_ack !== 1'b1 || bus.o_replay_ack !== 1'b0) begin failures++; $display("FAIL flush_resume_ack got=%0h/%0h exp=1/0", bus.o_sq_retire_ack, bus.o_replay_ack); end
        step();
        checks++; if (bus.o_valid !== 1'b1 || bus.o_retire !== 1'b1 || bus.o_addr !== 32'h2000) begin failures++; $display("FAIL flush_resume_out got=%0h/%0h/%h exp=1/1/2000", bus.o_valid, bus.o_retire, bus.o_addr); end
        idle();
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        set_retire_replay_fields();
        bus.i_valid = 1; bus.i_lsu_func = PCYN_LSU_FUNC_LW; bus.i_sq_retire_en = 1;
        step(); step(); step();
        checks++; if (bus.o_valid !== 1'b1 || dut.u_arb.starve_cnt !== 3'd3) begin failures++; $display("FAIL rstmid_pre got=%0h/%0d exp=1/3", bus.o_valid, dut.u_arb.starve_cnt); end
        n_rst = 1'b0;
        step();
        checks++; if (bus.o_valid !== 1'b0 || dut.u_arb.starve_cnt !== 3'd0 || bus.o_retire !== 1'b0) begin failures++; $display("FAIL rstmid_post got=%0h/%0d/%0h exp=0/0/0", bus.o_valid, dut.u_arb.starve_cnt, bus.o_retire); end
        n_rst = 1'b1;
        idle();
    endtask

`ifdef PCYN_LSU_AM_MISALIGN_EN
    task automatic test_misalign();
        clear_inputs();
        bus.i_valid = 1; bus.i_lsu_func = PCYN_LSU_FUNC_LH; bus.i_src_a = 32'h1000; bus.i_imm = 32'h1;
        #3;
        checks++; if (bus.o_alloc_lq !== 1'b1) begin failures++; $display("FAIL misalign_alloc got=%0h exp=1", bus.o_alloc_lq); end
        step();
        checks++; if (bus.o_misaligned !== 1'b1 || bus.o_addr !== 32'h1001) begin failures++; $display("FAIL misalign_lh got=%0h/%h exp=1/1001", bus.o_misaligned, bus.o_addr); end
        bus.i_lsu_func = PCYN_LSU_FUNC_LW; bus.i_imm = 32'h4;
        step();
        checks++; if (bus.o_misaligned !== 1'b0 || bus.o_valid !== 1'b1) begin failures++; $display("FAIL misalign_lw got=%0h/%0h exp=0/1", bus.o_misaligned, bus.o_valid); end
        bus.i_lsu_func = PCYN_LSU_FUNC_SW; bus.i_imm = 32'h2;
        step();
        checks++; if (bus.o_misaligned !== 1'b1) begin failures++; $display("FAIL misalign_sw got=%0h exp=1", bus.o_misaligned); end
        idle();
    endtask
`endif

    initial begin
        n_rst = 1'b0;
        clear_inputs();
        #1;
        test_reset();
        test_starvation();
        test_addr_wrap();
        test_sq_full();
        test_flush();
        test_reset_mid();
`ifdef PCYN_LSU_AM_MISALIGN_EN
        test_misalign();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
